// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
// Module      : game_timer
// Description : Frame-rate M:SS game clock (three BCD digits) plus a gravity
//               pacer whose drop period shortens with each elapsed minute.
//               Controlled by level start/pause/clear from the game FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module game_timer #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int DROP_BASE      = 48,
    parameter int DROP_STEP      = 8,
    parameter int DROP_MIN       = 4
) (
    input  logic       frame_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] gameClock [3],
    output logic       sec_tick,
    output logic       drop_tick,
    output logic       running,
    output logic       expired
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    // Last frame index of a second, and the gravity period constants at the
    // 12-bit width used for the period arithmetic.
    localparam logic [5:0]  c_fps_last  = 6'(FRAMES_PER_SEC - 1);
    localparam logic [11:0] c_drop_base = 12'(DROP_BASE);
    localparam logic [11:0] c_drop_step = 12'(DROP_STEP);
    localparam logic [11:0] c_drop_min  = 12'(DROP_MIN);
    localparam logic [11:0] c_floor_gap = 12'(DROP_BASE - DROP_MIN);

    state_t      state_q, state_d;
    logic [3:0]  min_q, min_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  units_q, units_d;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        sec_tick_q, sec_tick_d;
    logic        drop_tick_q, drop_tick_d;

    logic        w_sec_wrap;
    logic        w_carry_units;
    logic        w_carry_tens;
    logic [3:0]  w_units_inc;
    logic [3:0]  w_tens_inc;
    logic [3:0]  w_min_inc;
    logic        w_reach_end;
    logic [11:0] w_step_prod;
    logic [11:0] w_period;
    logic        w_drop_hit;

    // BCD one-second increment and the gravity period derived from the minute digit.
    always_comb begin
        w_sec_wrap    = (frame_cnt_q == c_fps_last);
        w_carry_units = (units_q == 4'd9);
        w_carry_tens  = w_carry_units && (tens_q == 4'd5);
        w_units_inc   = w_carry_units ? 4'd0 : units_q + 4'd1;
        if (w_carry_units) begin
            w_tens_inc = (tens_q == 4'd5) ? 4'd0 : tens_q + 4'd1;
        end else begin
            w_tens_inc = tens_q;
        end
        // Minutes saturate at 9; the timer expires at 9:59 before this could wrap.
        if (w_carry_tens && (min_q != 4'd9)) begin
            w_min_inc = min_q + 4'd1;
        end else begin
            w_min_inc = min_q;
        end
        w_reach_end = (w_min_inc == 4'd9) && (w_tens_inc == 4'd5) && (w_units_inc == 4'd9);

        w_step_prod = c_drop_step * {8'd0, min_q};
        if (w_step_prod >= c_floor_gap) begin
            w_period = c_drop_min;
        end else begin
            w_period = c_drop_base - w_step_prod;
        end
        // A >= test lets a period that just shrank below the count fire at once.
        w_drop_hit = ({4'd0, drop_cnt_q} >= (w_period - 12'd1));
    end

    // Next-state, counter and tick decode; clear overrides every state.
    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        tens_d      = tens_q;
        units_d     = units_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        sec_tick_d  = 1'b0;
        drop_tick_d = 1'b0;

        if (clear) begin
            state_d     = S_IDLE;
            min_d       = 4'd0;
            tens_d      = 4'd0;
            units_d     = 4'd0;
            frame_cnt_d = 6'd0;
            drop_cnt_d  = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_sec_wrap) begin
                        frame_cnt_d = 6'd0;
                        min_d       = w_min_inc;
                        tens_d      = w_tens_inc;
                        units_d     = w_units_inc;
                        sec_tick_d  = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 6'd1;
                    end
                    if (w_drop_hit) begin
                        drop_cnt_d  = 8'd0;
                        drop_tick_d = 1'b1;
                    end else begin
                        drop_cnt_d  = drop_cnt_q + 8'd1;
                    end
                    // Reaching 9:59 ends the game even if pause arrives on the same frame.
                    if (w_sec_wrap && w_reach_end) begin
                        state_d = S_EXPIRED;
                    end else if (pause) begin
                        state_d = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (start) begin
                        state_d = S_RUN;
                    end
                end
                S_EXPIRED: begin
                    state_d = S_EXPIRED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, digit, counter and tick registers with asynchronous reset.
    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            min_q       <= 4'd0;
            tens_q      <= 4'd0;
            units_q     <= 4'd0;
            frame_cnt_q <= 6'd0;
            drop_cnt_q  <= 8'd0;
            sec_tick_q  <= 1'b0;
            drop_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            tens_q      <= tens_d;
            units_q     <= units_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            sec_tick_q  <= sec_tick_d;
            drop_tick_q <= drop_tick_d;
        end
    end

    assign gameClock[2] = min_q;
    assign gameClock[1] = tens_q;
    assign gameClock[0] = units_q;
    assign sec_tick     = sec_tick_q;
    assign drop_tick    = drop_tick_q;
    assign running      = (state_q == S_RUN);
    assign expired      = (state_q == S_EXPIRED);

endmodule
`default_nettype wire

// File: tb/tb_game_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_timer
// Description : Scoreboard bench for game_timer. Stimulus pushes the frame
//               number and digits of every expected sec_tick and selected
//               drop_tick frames; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_timer;

    logic       frame_clk = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic       pause     = 1'b0;
    logic       clear     = 1'b0;
    logic [3:0] gc [3];
    logic       sec_tick;
    logic       drop_tick;
    logic       running;
    logic       expired;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int quiet_hits = 0;
    logic quiet    = 1'b0;

    int sq_cyc [$];
    int sq_dig [$];
    int dq_cyc [$];

    // Pause applied on counting frame 27025 (7:30 + 25 frames) for 100 edges.
    localparam int NP     = 27025;
    localparam int PAUSED = 100;

    game_timer dut (
        .frame_clk (frame_clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .gameClock (gc),
        .sec_tick  (sec_tick),
        .drop_tick (drop_tick),
        .running   (running),
        .expired   (expired)
    );

    always #5 frame_clk = ~frame_clk;

    // Rising-edge counter: at a negedge, cyc is the index of the last edge.
    always @(posedge frame_clk) cyc <= cyc + 1;

    function automatic int digs();
        return int'(gc[2]) * 100 + int'(gc[1]) * 10 + int'(gc[0]);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge frame_clk);
    endtask

    // Monitor: every sec_tick must match the head of the expected queue;
    // drop_tick frames listed in the drop queue must each be seen.
    int exp_c;
    int exp_d;
    always @(negedge frame_clk) begin
        if (sec_tick) begin
            checks++;
            if (sq_cyc.size() == 0) begin
                failures++;
                $display("FAIL sec_tick_unexpected frame=%0d digits=%0d required=none", cyc, digs());
            end else begin
                exp_c = sq_cyc.pop_front();
                exp_d = sq_dig.pop_front();
                if (exp_c != cyc || exp_d != digs()) begin
                    failures++;
                    $display("FAIL sec_tick frame=%0d digits=%0d required frame=%0d digits=%0d",
                             cyc, digs(), exp_c, exp_d);
                end
            end
        end
        if (drop_tick) begin
            while (dq_cyc.size() > 0 && dq_cyc[0] < cyc) begin
                checks++;
                failures++;
                $display("FAIL drop_tick_missed actual=none required frame=%0d", dq_cyc.pop_front());
            end
            if (dq_cyc.size() > 0 && dq_cyc[0] == cyc) begin
                checks++;
                void'(dq_cyc.pop_front());
            end
        end
        if (quiet && (sec_tick || drop_tick)) quiet_hits++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int e2;
        int n;
        @(negedge frame_clk);
        chk("reset_digits", digs(), 0);
        chk("reset_flags", {sec_tick, drop_tick, running, expired}, 0);
        reset = 1'b0;
        pause = 1'b1;
        repeat (3) @(negedge frame_clk);
        chk("idle_ignores_pause", running, 0);
        pause = 1'b0;

        // ---- Run 1: 0:00 through 9:59 with one pause in minute 7 ----
        e = cyc + 1;
        start = 1'b1;
        for (int s = 1; s <= 599; s++) begin
            n = 60 * s;
            sq_cyc.push_back(e + n + ((n > NP) ? PAUSED : 0));
            sq_dig.push_back((s / 60) * 100 + ((s % 60) / 10) * 10 + (s % 10));
        end
        dq_cyc.push_back(e + 48);
        dq_cyc.push_back(e + 96);
        dq_cyc.push_back(e + 3600);
        dq_cyc.push_back(e + 3640);
        dq_cyc.push_back(e + 3680);
        dq_cyc.push_back(e + 14401);
        dq_cyc.push_back(e + 21601);
        dq_cyc.push_back(e + 21605);
        dq_cyc.push_back(e + 21609);
        dq_cyc.push_back(e + NP);
        dq_cyc.push_back(e + NP + 4 + PAUSED);
        @(negedge frame_clk);
        start = 1'b0;
        chk("running_after_start", running, 1);

        wait_cyc(e + 60);
        chk("digits_0_01", digs(), 1);

        wait_cyc(e + NP - 1);
        pause = 1'b1;
        wait_cyc(e + NP + 1);
        quiet = 1'b1;
        chk("paused_not_running", running, 0);
        wait_cyc(e + NP + PAUSED - 1);
        chk("paused_digits_hold", digs(), 730);
        pause = 1'b0;
        start = 1'b1;
        wait_cyc(e + NP + PAUSED);
        start = 1'b0;
        quiet = 1'b0;
        chk("no_ticks_while_paused", quiet_hits, 0);
        chk("resumed_running", running, 1);

        wait_cyc(e + 35940 + PAUSED);
        chk("expired_flag", expired, 1);
        chk("expired_not_running", running, 0);
        chk("expired_digits", digs(), 959);
        start = 1'b1;
        pause = 1'b1;
        wait_cyc(e + 35941 + PAUSED);
        quiet = 1'b1;
        wait_cyc(e + 36140 + PAUSED);
        chk("expired_hold_digits", digs(), 959);
        chk("expired_hold_flag", expired, 1);
        chk("no_ticks_after_expiry", quiet_hits, 0);
        quiet = 1'b0;
        pause = 1'b0;

        // clear together with start: ends in IDLE at 0:00
        clear = 1'b1;
        @(negedge frame_clk);
        clear = 1'b0;
        start = 1'b0;
        chk("clear_digits", digs(), 0);
        chk("clear_flags", {running, expired}, 0);
        repeat (5) @(negedge frame_clk);
        chk("idle_needs_start", running, 0);

        // ---- Run 2: reset asynchronously at 3:27 ----
        e2 = cyc + 1;
        start = 1'b1;
        for (int s = 1; s <= 207; s++) begin
            sq_cyc.push_back(e2 + 60 * s);
            sq_dig.push_back((s / 60) * 100 + ((s % 60) / 10) * 10 + (s % 10));
        end
        dq_cyc.push_back(e2 + 48);
        dq_cyc.push_back(e2 + 3640);
        @(negedge frame_clk);
        start = 1'b0;
        wait_cyc(e2 + 12430);
        chk("run2_digits_3_27", digs(), 327);
        chk("run2_running", running, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_digits", digs(), 0);
        chk("async_reset_flags", {sec_tick, drop_tick, running, expired}, 0);
        @(negedge frame_clk);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (100) @(negedge frame_clk);
        quiet = 1'b0;
        chk("post_reset_idle", running, 0);
        chk("post_reset_digits", digs(), 0);
        chk("post_reset_quiet", quiet_hits, 0);

        chk("sec_queue_drained", sq_cyc.size(), 0);
        chk("drop_queue_drained", dq_cyc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_timer.md
# game_timer

Frame-rate game timer and gravity pacer for the Tetris display pipeline. It produces the three BCD digits (`gameClock`) that the color mapper renders as the on-screen M:SS timer. It also produces a per-frame gravity pulse whose period shortens as the game clock advances. All logic runs on `frame_clk` (one edge per displayed frame, nominally 60 Hz) and is controlled by level inputs from the game FSM.

## Interface
Parameters:
- `FRAMES_PER_SEC`, 60: frames per displayed second; range 2..63.
- `DROP_BASE`, 48: gravity period, in frames, at minute 0; range 1..255.
- `DROP_STEP`, 8: frames removed from the gravity period per elapsed minute.
- `DROP_MIN`, 4: floor on the gravity period; range 1..`DROP_BASE`.

Ports:
- `frame_clk`, input, 1: frame clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high; clock `frame_clk`.
- `start`, input, 1: level, sampled each edge; starts or resumes counting.
- `pause`, input, 1: level, sampled each edge; freezes counting.
- `clear`, input, 1: level, sampled each edge; returns to IDLE at 0:00.
- `gameClock[3]`, output, 4 each (unpacked): BCD digits.
  - [2] = minutes, 0..9.
  - [1] = tens of seconds, 0..5.
  - [0] = units of seconds, 0..9.
- `sec_tick`, output, 1: one-frame pulse; high on the frame in which the digits changed.
- `drop_tick`, output, 1: one-frame gravity pulse.
- `running`, output, 1: high while in RUN.
- `expired`, output, 1: high while in EXPIRED.

## Operation
State machine: IDLE, RUN, PAUSED, EXPIRED.
- `clear` has top priority in every state. It moves to IDLE and zeroes the digits, `frame_cnt` and `drop_cnt`.
- IDLE: `start` moves to RUN. `pause` is ignored.
- RUN: `pause` moves to PAUSED; pause beats a simultaneous `start`.
- RUN: if the digits reach 9:59 on this edge, move to EXPIRED.
- PAUSED: `start` moves to RUN; start beats a simultaneous `pause`. All counters hold their values.
- EXPIRED: the digits hold 9:59. Only `clear` (or `reset`) exits.

Frame counter `frame_cnt` (6 bits). It increments only on edges where the pre-edge state is RUN.
- When `frame_cnt == FRAMES_PER_SEC-1`: set `frame_cnt` to 0, increment the digits by one second, and set `sec_tick` to 1.
- The increment is BCD with carries:
  - [0] goes from 9 to 0 and carries into [1].
  - [1] goes from 5 to 0 and carries into [2].
  - [2] never exceeds 9.
  - No digit ever holds a non-BCD value.

Gravity counter `drop_cnt` (8 bits). It also advances only while in RUN.
- Period: `P = DROP_MIN` if `DROP_STEP*gameClock[2] >= DROP_BASE-DROP_MIN`; otherwise `P = DROP_BASE - DROP_STEP*gameClock[2]`.
- Compute `P` at 12-bit width so it can never go negative or wrap.
- When `drop_cnt >= P-1`: set `drop_cnt` to 0 and set `drop_tick` to 1. The `>=` comparison means a shrinking period takes effect without a missed pulse.

`sec_tick` and `drop_tick` are registered. They are 0 on every edge that does not meet the conditions above, including all edges outside RUN.

`running` and `expired` decode the state register directly, with no extra delay.

## Timing
- Reset values: state IDLE, all `gameClock` digits 0, `frame_cnt` 0, `drop_cnt` 0. All outputs (`sec_tick`, `drop_tick`, `running`, `expired`) are 0.
- Reset is asynchronous: asserting it mid-count forces these values immediately. After release, the block waits in IDLE for `start`.
- With `start` sampled at edge 0 (state becomes RUN), edges 1..N are counting edges:
  - Digits show 0:01 after edge `FRAMES_PER_SEC` (edge 60 at default).
  - `sec_tick` is high for the frame following that edge.
  - First `drop_tick` is asserted after edge `DROP_BASE` (edge 48).
- A pause applied at edge k freezes counts at their edge-k values. Resuming continues from those values, so no frames are lost or gained.
- Entry to EXPIRED happens on the same edge that produces 9:59. `sec_tick` is asserted on that edge; no further ticks follow.
- `clear` and `start` sampled on the same edge: the result is IDLE. A separate `start` edge is needed afterwards.

## Test plan
- Reset, then `start` for 1 frame, then run 60 frames: `gameClock` = {0,0,1}, `sec_tick` pulses once (1 frame), `running` = 1.
- Run 600 frames from 0:00: digits step 0:09 to 0:10 at frame 600 (default `FRAMES_PER_SEC` = 60). Checks [0] to [1] carry and that no hex digits appear.
- Run to 0:59 then 60 more frames: digits = 1:00. `drop_tick` period changes from 48 to 40 frames.
- Assert `pause` for 100 frames mid-second, then `start`: total RUN frames to the next `sec_tick` equals 60 exactly. No ticks occur while paused.
- Run to 9:59: `expired` = 1, `running` = 0, digits hold 9:59 for 200 further frames. At minutes ≥ 6 the `drop_tick` period is 4 frames. `clear` then gives IDLE at 0:00.
- Assert `reset` asynchronously mid-frame during RUN at 3:27: all outputs 0 immediately, digits 0:00. After release, no counting occurs until `start`.
